term_seq_ctrl: RTL and testbench



---
 rtl/term_seq_pkg.sv | 23 ++
 rtl/term_seq_cnt.sv | 43 ++++
 rtl/term_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_term_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_seq_pkg.sv
// Shared types and helpers for the term_seq terminal-control sequencer.
package term_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned CH_DEF    = 4;
  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned SEL_W_DEF = 2;
  localparam int unsigned CH_MAX    = 16;

  // A channel qualifies when it is requesting and either threshold is met.
  function automatic logic [CH_MAX-1:0] match_f(input logic [CH_MAX-1:0] req,
                                                input logic [CH_MAX-1:0] a,
                                                input logic [CH_MAX-1:0] b);
    return req & (a | b);
  endfunction

endpackage

// File: rtl/term_seq_cnt.sv
// Step counter for term_seq_ctrl: clear, gated increment, hold, terminal-hit flag.
// TERM_SEQ_PARITY_EN additionally exposes the next-count value.
module term_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         hold,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt,
`ifdef TERM_SEQ_PARITY_EN
  output logic [W-1:0] nxt,
`endif
  output logic         hit
);

  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr)
      cnt_d = '0;
    else if (inc && !hold)
      cnt_d = cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_d;
  end

  // Widened compare so cnt+1 cannot alias when cnt is all ones.
  assign hit = (({1'b0, cnt} + (W+1)'(1)) == {1'b0, lim});

`ifdef TERM_SEQ_PARITY_EN
  assign nxt = cnt_d;
`endif

endmodule

// File: rtl/term_seq_ctrl.sv
// Registered, parametrised terminal-control sequencer with start/done/ack handshake.
// Optional TERM_SEQ_PARITY_EN adds an even-parity output over {cnt, match_vec}.
module term_seq_ctrl
  import term_seq_pkg::*;
#(
  parameter int unsigned CH    = CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  input  logic                  hold,
  input  logic [CH-1:0]         req_vec,
  input  logic [CH-1:0]         thr_a,
  input  logic [CH-1:0]         thr_b,
  input  logic [CNT_W-1:0]      limit,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [(1<<SEL_W)-1:0] bank_n,
  input  logic                  ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      cnt,
  output logic                  sel_out,
  output logic [CH-1:0]         match_vec
`ifdef TERM_SEQ_PARITY_EN
  ,
  output logic                  parity
`endif
);

  state_t           state;
  logic [CH-1:0]    req_q;
  logic [CNT_W-1:0] lim_q;
  logic [CH-1:0]    match_d;
  logic             go;
  logic             hit;
`ifdef TERM_SEQ_PARITY_EN
  logic [CNT_W-1:0] cnt_nxt;
`endif

  assign go = (state == IDLE) && start && en && !hold;

  always_comb begin
    match_d = match_vec;
    if (state == ARM)
      match_d = CH'(match_f(CH_MAX'(req_q), CH_MAX'(thr_a), CH_MAX'(thr_b)));
  end

  term_seq_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (go),
    .inc  (state == COUNT),
    .hold (hold),
    .lim  (lim_q),
    .cnt  (cnt),
`ifdef TERM_SEQ_PARITY_EN
    .nxt  (cnt_nxt),
`endif
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sel_out   <= 1'b0;
      match_vec <= '0;
      req_q     <= '0;
      lim_q     <= '0;
    end else begin
      sel_out   <= ~bank_n[cfg_sel];
      match_vec <= match_d;
      case (state)
        IDLE: begin
          if (go) begin
            req_q <= req_vec;
            lim_q <= limit;
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          if (match_d == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= DONE;
          end else if (lim_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= COUNT;
          end
        end
        COUNT: begin
          // hit looks at the pre-increment count, so the final step and exit share an edge.
          if (!hold && hit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (ack) begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TERM_SEQ_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)
      parity <= 1'b0;
    else
      parity <= ^{cnt_nxt, match_d};
  end
`endif

endmodule

// File: tb/tb_term_seq_ctrl.sv
// Scoreboard bench for term_seq_ctrl: driver queues expected results, monitor checks on done.
module tb_term_seq_ctrl;

  localparam int CH = 4;
  localparam int CW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst, start, en, hold, ack;
  logic [CH-1:0] req_vec, thr_a, thr_b;
  logic [CW-1:0] limit;
  logic [SW-1:0] cfg_sel;
  logic [(1<<SW)-1:0] bank_n;
  logic busy, done, err, sel_out;
  logic [CW-1:0] cnt;
  logic [CH-1:0] match_vec;
`ifdef TERM_SEQ_PARITY_EN
  logic parity;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [CH-1:0] match;
    logic          err;
    logic [CW-1:0] cnt;
    int            lat;
    int            w;
    int            start_cyc;
  } exp_t;

  exp_t q[$];

  term_seq_ctrl #(
    .CH    (CH),
    .CNT_W (CW),
    .SEL_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en        (en),
    .hold      (hold),
    .req_vec   (req_vec),
    .thr_a     (thr_a),
    .thr_b     (thr_b),
    .limit     (limit),
    .cfg_sel   (cfg_sel),
    .bank_n    (bank_n),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cnt       (cnt),
    .sel_out   (sel_out),
    .match_vec (match_vec)
`ifdef TERM_SEQ_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_misc();
    cfg_sel = SW'($urandom);
    bank_n  = (1<<SW)'($urandom);
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   have_cur  = 0;
  logic done_prev = 1'b0;
  int   busy_cnt  = 0;
  int   done_len  = 0;
  logic exp_sel   = 1'b0;

  always @(posedge clk) exp_sel <= rst ? 1'b0 : ~bank_n[cfg_sel];

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      done_len  = 0;
      done_prev = 1'b0;
      have_cur  = 0;
    end else begin
      check("sel_out", sel_out, exp_sel);
`ifdef TERM_SEQ_PARITY_EN
      check("parity", parity, ^{cnt, match_vec});
`endif
      check("busy_done_excl", busy & done, 0);
      if (busy) busy_cnt++;
      if (done && !done_prev) begin
        check("done_has_expect", q.size() != 0, 1);
        if (q.size() != 0) begin
          cur      = q.pop_front();
          have_cur = 1;
          done_len = 0;
          check("match_vec", match_vec, cur.match);
          check("err", err, cur.err);
          check("latency", cyc - cur.start_cyc, cur.lat);
          check("busy_cycles", busy_cnt, cur.lat);
        end
      end
      if (done) begin
        done_len++;
        if (have_cur) check("cnt_in_done", cnt, cur.cnt);
      end
      if (!done && done_prev && have_cur) begin
        check("done_len", done_len, cur.w);
        check("cnt_after_ack", cnt, cur.cnt);
        check("err_after_ack", err, 0);
        busy_cnt = 0;
        have_cur = 0;
      end
      done_prev = done;
    end
  end

  // ---------------- driver ----------------
  // hold_at < 0: random holds; otherwise hold 3 cycles when the model count equals hold_at.
  task automatic run_seq(input logic [CH-1:0] req, input logic [CH-1:0] a,
                         input logic [CH-1:0] b, input logic [CW-1:0] lim,
                         input int hold_at, input bit both);
    exp_t e;
    bit   hl[$];
    int   c  = 0;
    int   hc = 0;
    logic [CH-1:0] m;
    m = req & (a | b);
    if (m != 0 && lim != 0) begin
      while (c < int'(lim)) begin
        bit h;
        if (hold_at >= 0) h = (c == hold_at) && (hc < 3);
        else              h = ($urandom_range(0, 3) == 0);
        if (h) hc++;
        else   c++;
        hl.push_back(h);
      end
    end
    e.match = m;
    e.err   = (m == 0);
    e.cnt   = (m == 0) ? '0 : lim;
    e.lat   = 1 + hl.size();
    e.w     = both ? 1 : $urandom_range(1, 4);

    req_vec = req; limit = lim; start = 1'b1; en = 1'b1; hold = 1'b0; ack = 1'b0;
    thr_a = CH'($urandom); thr_b = CH'($urandom); rand_misc();
    step();
    e.start_cyc = cyc;
    q.push_back(e);

    // ARM cycle: thresholds must be valid now; captured fields get noise.
    start = 1'b0; thr_a = a; thr_b = b;
    req_vec = CH'($urandom); limit = CW'($urandom); en = 1'($urandom);
    hold = 1'($urandom); ack = 1'($urandom); rand_misc();
    step();

    foreach (hl[i]) begin
      hold = hl[i]; start = 1'($urandom); en = 1'($urandom); ack = 1'($urandom);
      req_vec = CH'($urandom); limit = CW'($urandom);
      thr_a = CH'($urandom); thr_b = CH'($urandom); rand_misc();
      step();
    end

    for (int i = 1; i < e.w; i++) begin
      ack = 1'b0; start = 1'($urandom); hold = 1'($urandom); en = 1'($urandom); rand_misc();
      step();
    end
    ack = 1'b1; start = both ? 1'b1 : 1'($urandom); en = 1'b1; hold = 1'b0; rand_misc();
    step();

    // Idle gap: a start that must be refused because of en or hold.
    ack = 1'b0; start = 1'b1;
    if ($urandom_range(0, 1) == 0) begin en = 1'b0; hold = 1'b0; end
    else                           begin en = 1'b1; hold = 1'b1; end
    rand_misc();
    step();
    start = 1'b0; en = 1'b1; hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'($urandom); en = 1'($urandom); hold = 1'($urandom); ack = 1'($urandom);
    req_vec = CH'($urandom); thr_a = CH'($urandom); thr_b = CH'($urandom);
    limit = CW'($urandom); rand_misc();
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", cnt, 0);
    check("rst_match", match_vec, 0);
    check("rst_sel", sel_out, 0);
`ifdef TERM_SEQ_PARITY_EN
    check("rst_parity", parity, 0);
`endif
    rst = 1'b0; start = 1'b0; en = 1'b1; hold = 1'b0; ack = 1'b0;
    cfg_sel = 2'd2; bank_n = 4'b1011;
    step();
    check("sel_dir", sel_out, 1);

    run_seq(4'b0110, 4'b0010, 4'b0000, 4'd5, 99, 0);
    run_seq(4'b1000, 4'b0000, 4'b0000, 4'd3, 99, 0);
    run_seq(4'b0101, 4'b0100, 4'b0001, 4'd4, 2, 0);
    run_seq(4'b0011, 4'b0001, 4'b0010, 4'd0, 99, 1);
    run_seq(4'b1111, 4'b1111, 4'b0000, 4'd15, -1, 0);

    for (int n = 0; n < 60; n++)
      run_seq(CH'($urandom), CH'($urandom), CH'($urandom), CW'($urandom_range(0, 15)),
              -1, ($urandom_range(0, 3) == 0));

    // Reset in the middle of counting.
    req_vec = 4'b0001; thr_a = 4'b0001; thr_b = 4'b0000; limit = 4'd10;
    start = 1'b1; en = 1'b1; hold = 1'b0; ack = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_cnt", cnt, 3);
    check("mid_busy", busy, 1);
    check("mid_match", match_vec, 4'b0001);
`ifdef TERM_SEQ_PARITY_EN
    check("mid_parity", parity, 1);
`endif
    rst = 1'b1;
    step();
    check("rst2_busy", busy, 0);
    check("rst2_cnt", cnt, 0);
    check("rst2_done", done, 0);
    check("rst2_match", match_vec, 0);
    rst = 1'b0;
    q.delete();
    step();

    run_seq(4'b1010, 4'b0010, 4'b1000, 4'd6, -1, 0);
    for (int i = 0; i < 3; i++) step();
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
